// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One shift-subtract step per cycle on operand magnitudes, sign fix-up at the end.
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic             op_rem,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_a;
   logic             sign_b;
   logic             rem_sel;
   logic             sgn_sel;
   logic             zero_div;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // operand magnitudes; unsigned ops pass straight through
   assign abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // one restoring step: shift next dividend bit in, trial-subtract divisor
   assign shifted = {prem[WIDTH-1:0], quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};

   // quotient negative iff signs differ; remainder follows the dividend
   assign q_fix = (sgn_sel && (sign_a ^ sign_b)) ? -quo : quo;
   assign r_fix = (sgn_sel && sign_a) ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];

   assign busy = (state != IDLE);

   // controller and datapath; zero divisor spends one idle RUN cycle before FIN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         prem        <= '0;
         quo         <= '0;
         dvs         <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         rem_sel     <= 1'b0;
         sgn_sel     <= 1'b0;
         zero_div    <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign_a  <= dividend[WIDTH-1];
                  sign_b  <= divisor[WIDTH-1];
                  rem_sel <= op_rem;
                  sgn_sel <= is_signed;
                  prem    <= '0;
                  state   <= RUN;
                  if (divisor == '0) begin
                     zero_div <= 1'b1;
                     quo      <= dividend;
                     dvs      <= '0;
                     count    <= CW'(WIDTH - 1);
                  end else begin
                     zero_div <= 1'b0;
                     quo      <= abs_a;
                     dvs      <= abs_b;
                     count    <= '0;
                  end
               end
            end
            RUN: begin
               if (!zero_div) begin
                  if (!diff[WIDTH]) begin
                     prem <= diff;
                     quo  <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     prem <= shifted;
                     quo  <= {quo[WIDTH-2:0], 1'b0};
                  end
               end
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) state <= FIN;
            end
            FIN: begin
               done        <= 1'b1;
               div_by_zero <= zero_div;
               if (zero_div) result <= rem_sel ? quo : '1;
               else          result <= rem_sel ? r_fix : q_fix;
               count <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: random and directed ops against an arithmetic reference,
// checked by a scoreboard monitor on every done pulse.
module tb_iter_divider;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic         is_signed;
   logic         op_rem;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         div_by_zero;

   typedef struct {
      logic [W-1:0] res;
      logic         dz;
      int           done_cyc;
      int           busy_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   iter_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_signed   (is_signed),
      .op_rem      (op_rem),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: RISC-V division rules in plain 64-bit arithmetic
   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                  bit s, bit r);
      exp_t   e;
      longint sa;
      longint sbv;
      longint q;
      longint m;
      e.done_cyc = 0;
      e.busy_cyc = 0;
      if (b == 0) begin
         e.res = r ? a : {W{1'b1}};
         e.dz  = 1'b1;
      end else if (s) begin
         sa    = longint'($signed(a));
         sbv   = longint'($signed(b));
         q     = sa / sbv;
         m     = sa % sbv;
         e.res = r ? m[W-1:0] : q[W-1:0];
         e.dz  = 1'b0;
      end else begin
         e.res = r ? (a % b) : (a / b);
         e.dz  = 1'b0;
      end
      return e;
   endfunction

   // monitor: every done pulse must match the oldest outstanding op
   initial begin
      int   bc;
      exp_t e;
      bc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bc = 0;
         end else begin
            if (busy) bc++;
            if (done) begin
               check("busy_low_in_done", {63'd0, busy}, 64'd0);
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_done: got result %h expected no done", result);
               end else begin
                  e = sb.pop_front();
                  check("result", {32'd0, result}, {32'd0, e.res});
                  check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                  check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                  check("busy_cycles", 64'(bc), 64'(e.busy_cyc));
               end
               bc = 0;
            end
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   // drive one op; returns #1 after the accepting edge
   task automatic issue(logic [W-1:0] a, logic [W-1:0] b, bit s, bit r);
      exp_t e;
      wait_idle();
      dividend  = a;
      divisor   = b;
      is_signed = s;
      op_rem    = r;
      start     = 1'b1;
      e          = model(a, b, s, r);
      e.done_cyc = cyc + 1 + ((b == 0) ? 2 : W + 1);
      e.busy_cyc = (b == 0) ? 2 : W + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start     = 1'b0;
      dividend  = $urandom;
      divisor   = $urandom;
      is_signed = 1'($urandom);
      op_rem    = 1'($urandom);
   endtask

   function automatic logic [W-1:0] pick(int k);
      logic [W-1:0] v;
      case (k)
         0:       v = '0;
         1:       v = 32'd1;
         2:       v = 32'h8000_0000;
         3:       v = 32'hFFFF_FFFF;
         4:       v = 32'($urandom_range(0, 300));
         5:       v = -32'($urandom_range(1, 300));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int g;
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      op_rem    = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_dz", {63'd0, div_by_zero}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      issue(32'd100, 32'd7, 1'b0, 1'b0);
      issue(-32'sd7, 32'd2, 1'b1, 1'b0);
      issue(-32'sd7, 32'd2, 1'b1, 1'b1);
      issue(32'h1234, 32'd0, 1'b0, 1'b0);
      issue(32'h1234, 32'd0, 1'b1, 1'b1);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      issue(32'h8000_0000, 32'd3, 1'b0, 1'b0);

      // start pulsed mid-run with other operands must be ignored
      issue(32'd1000, 32'd9, 1'b0, 1'b0);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      dividend = 32'd5;
      divisor  = 32'd0;
      op_rem   = 1'b1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // back-to-back: accepted in the done cycle
      issue(32'd77, 32'd5, 1'b0, 1'b1);
      issue(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 1'b0);

      // abort mid-run: outputs clear and no done follows
      wait_idle();
      issue(32'd12345, 32'd17, 1'b0, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_result", {32'd0, result}, 64'd0);
      check("abort_dz", {63'd0, div_by_zero}, 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
      end
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         issue(pick($urandom_range(0, 9)), pick($urandom_range(0, 9)),
               1'($urandom), 1'($urandom));
      end

      g = 0;
      while (sb.size() > 0 && g < 200) begin
         @(posedge clk);
         #1;
         g++;
      end
      check("drain", 64'(sb.size()), 64'd0);
      repeat (3) @(posedge clk);
      // results hold without a new start
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
